// File: rtl/ks_wide_to_narrow_fifo_pkg.sv
// Shared widths, derivation helpers and serialiser state encoding for the
// ChaCha20 keystream wide-to-narrow FIFO.
package ks_wide_to_narrow_fifo_pkg;

   localparam int CHACHA_BLK_W = 512;
   localparam int KS_SLICE_W   = 128;
   localparam int KS_ADDR_W    = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SER  = 1'b1
   } ser_state_e;

   function automatic int ratio_f(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   function automatic int level_w_f(input int a_w);
      return a_w + 1;
   endfunction

endpackage

// File: rtl/ks_wide_to_narrow_fifo_if.sv
// Block-write / slice-read bus of the keystream FIFO; the FIFO sits on the
// slave modport, the producer/consumer pair on the master modport.
interface ks_wide_to_narrow_fifo_if #(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 128,
   parameter int A_WIDTH   = 3
);
   logic                 i_w_valid;
   logic                 o_w_ready;
   logic [IN_WIDTH-1:0]  i_data;
   logic                 i_r_en;
   logic [OUT_WIDTH-1:0] o_data;
   logic                 o_r_valid;
   logic                 o_full;
   logic                 o_empty;
   logic [A_WIDTH:0]     o_level;
   logic                 o_underflow;

   modport master (
      output i_w_valid, i_data, i_r_en,
      input  o_w_ready, o_data, o_r_valid, o_full, o_empty, o_level, o_underflow
   );

   modport slave (
      input  i_w_valid, i_data, i_r_en,
      output o_w_ready, o_data, o_r_valid, o_full, o_empty, o_level, o_underflow
   );
endinterface

// File: rtl/ram_dual_sync.sv
// Simple dual-port synchronous RAM: port A writes, port B reads with one
// cycle latency into an output register that holds between reads.
module ram_dual_sync #(
   parameter int D_WIDTH = 128,
   parameter int A_WIDTH = 3
) (
   input  logic               clk_a,
   input  logic               we_a,
   input  logic [A_WIDTH-1:0] addr_a,
   input  logic [D_WIDTH-1:0] din_a,
   input  logic               clk_b,
   input  logic               rstn_b,
   input  logic               re_b,
   input  logic [A_WIDTH-1:0] addr_b,
   output logic [D_WIDTH-1:0] dout_b
);
   localparam int DEPTH = 1 << A_WIDTH;

   logic [D_WIDTH-1:0] mem_q [DEPTH];
   logic [D_WIDTH-1:0] dout_q;

   // NOTE: the storage array has no reset so it maps onto RAM macros; only
   // the small output register is reset.
   always_ff @(posedge clk_a) begin
      if (we_a) begin
         mem_q[addr_a] <= din_a;
      end
   end

   always_ff @(posedge clk_b or negedge rstn_b) begin
      if (!rstn_b) begin
         dout_q <= '0;
      end else if (re_b) begin
         dout_q <= mem_q[addr_b];
      end
   end

   assign dout_b = dout_q;
endmodule

// File: rtl/ks_wide_to_narrow_fifo.sv
// Keystream width-converting FIFO: accepts a wide ChaCha20 block, serialises
// it LSB slice first into a dual-port RAM, and serves slices to the consumer.
module ks_wide_to_narrow_fifo
   import ks_wide_to_narrow_fifo_pkg::*;
#(
   parameter int IN_WIDTH  = CHACHA_BLK_W,
   parameter int OUT_WIDTH = KS_SLICE_W,
   parameter int A_WIDTH   = KS_ADDR_W
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic                      i_clr,
   ks_wide_to_narrow_fifo_if.slave   bus
);
   localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
   localparam int DEPTH = 1 << A_WIDTH;
   localparam int LVL_W = level_w_f(A_WIDTH);
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || RATIO > DEPTH) begin : g_bad_params
      $error("ks_wide_to_narrow_fifo: IN_WIDTH must be a multiple of OUT_WIDTH with 2 <= RATIO <= DEPTH");
   end

   ser_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
   logic [A_WIDTH-1:0]   wptr_q, wptr_d;
   logic [A_WIDTH-1:0]   rptr_q, rptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 r_valid_q, r_valid_d;
   logic                 underflow_q, underflow_d;

   logic busy, empty, full, w_ready, w_acc, ser_we, r_acc;

   // Ready only looks at registers and the flush, never at i_w_valid, and
   // reserves a full block's worth of free slots up front.
   always_comb begin
      busy    = (state_q == ST_SER);
      empty   = (level_q == '0);
      full    = (level_q == LVL_W'(DEPTH));
      w_ready = !busy && !i_clr && ((LVL_W'(DEPTH) - level_q) >= LVL_W'(RATIO));
      w_acc   = bus.i_w_valid && w_ready;
      ser_we  = busy && !i_clr;
      r_acc   = bus.i_r_en && !empty && !i_clr;
   end

   // NOTE: every _d is given its default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;
      r_valid_d   = r_acc;
      underflow_d = underflow_q | (bus.i_r_en && empty);

      if (i_clr) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         shreg_d     = '0;
         wptr_d      = '0;
         rptr_d      = '0;
         level_d     = '0;
         r_valid_d   = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (w_acc) begin
            state_d = ST_SER;
            cnt_d   = '0;
            shreg_d = bus.i_data;
         end
         if (ser_we) begin
            shreg_d = shreg_q >> OUT_WIDTH;
            wptr_d  = wptr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(RATIO - 1)) begin
               state_d = ST_IDLE;
            end
         end
         if (r_acc) begin
            rptr_d = rptr_q + 1'b1;
         end
         case ({ser_we, r_acc})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // NOTE: clocked processes use non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         r_valid_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         r_valid_q   <= r_valid_d;
         underflow_q <= underflow_d;
      end
   end

   ram_dual_sync #(
      .D_WIDTH (OUT_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_ram (
      .clk_a  (i_clk),
      .we_a   (ser_we),
      .addr_a (wptr_q),
      .din_a  (shreg_q[OUT_WIDTH-1:0]),
      .clk_b  (i_clk),
      .rstn_b (i_rstn),
      .re_b   (r_acc),
      .addr_b (rptr_q),
      .dout_b (bus.o_data)
   );

   assign bus.o_w_ready   = w_ready;
   assign bus.o_r_valid   = r_valid_q;
   assign bus.o_full      = full;
   assign bus.o_empty     = empty;
   assign bus.o_level     = level_q;
   assign bus.o_underflow = underflow_q;

   // The reservation in w_ready makes a write into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn) !(ser_we && full))
      else $error("serialiser wrote into a full FIFO");

endmodule

// File: tb/tb_ks_wide_to_narrow_fifo.sv
// Directed bench for ks_wide_to_narrow_fifo: a vector table for the basic
// round trip, then hand-written sequences for the multi-cycle corner cases.
module tb_ks_wide_to_narrow_fifo;
   localparam int IN_W  = 512;
   localparam int OUT_W = 128;
   localparam int AW    = 3;
   localparam int RATIO = IN_W / OUT_W;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic clr  = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ks_wide_to_narrow_fifo_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .A_WIDTH(AW)) bus ();

   ks_wide_to_narrow_fifo #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .A_WIDTH(AW)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_clr  (clr),
      .bus    (bus.slave)
   );

   typedef struct {
      logic         w_valid;
      logic         r_en;
      logic [3:0]   exp_level;
      logic         exp_rv;
      logic         chk_data;
      logic [127:0] exp_data;
      logic         exp_ready;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] wd(input int base, input int i);
      return {32'(base), 32'(i), 32'hDEAD_BEEF ^ 32'(base * 4 + i), ~32'(base + i)};
   endfunction

   function automatic logic [511:0] mk(input int base);
      return {wd(base, 3), wd(base, 2), wd(base, 1), wd(base, 0)};
   endfunction

   task automatic do_reset();
      clr           = 1'b0;
      bus.i_w_valid = 1'b0;
      bus.i_r_en    = 1'b0;
      rstn          = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      #1;
   endtask

   task automatic write_block(input logic [511:0] blk);
      int n;
      n             = 0;
      bus.i_data    = blk;
      bus.i_w_valid = 1'b1;
      #1;
      while (!bus.o_w_ready && n < 20) begin
         tick();
         n++;
      end
      check("wr_ready_wait", 128'(bus.o_w_ready), 128'd1);
      tick();
      bus.i_w_valid = 1'b0;
      repeat (RATIO) tick();
   endtask

   task automatic read_block(input int base);
      for (int i = 0; i < RATIO; i++) begin
         bus.i_r_en = 1'b1;
         tick();
         check($sformatf("rd%0d_valid%0d", base, i), 128'(bus.o_r_valid), 128'd1);
         check($sformatf("rd%0d_data%0d", base, i), bus.o_data, wd(base, i));
      end
      bus.i_r_en = 1'b0;
      tick();
      check($sformatf("rd%0d_valid_drop", base), 128'(bus.o_r_valid), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] d [4];
      logic [511:0] blk;
      int           acc_a;
      int           acc_b;

      d[0] = 128'h0000_0000_1111_1111_2222_2222_3333_3333;
      d[1] = 128'h4444_4444_5555_5555_6666_6666_7777_7777;
      d[2] = 128'h8888_8888_9999_9999_AAAA_AAAA_BBBB_BBBB;
      d[3] = 128'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE_FFFF_FFFF;
      blk  = {d[3], d[2], d[1], d[0]};

      //           w_v   r_en  level  rv    chk   data    ready
      vecs[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 128'h0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 128'h0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 128'h0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 128'h0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 4'd3, 1'b1, 1'b1, d[0],   1'b1};
      vecs[6] = '{1'b0, 1'b1, 4'd2, 1'b1, 1'b1, d[1],   1'b1};
      vecs[7] = '{1'b0, 1'b1, 4'd1, 1'b1, 1'b1, d[2],   1'b1};
      vecs[8] = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b1, d[3],   1'b1};
      vecs[9] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, d[3],   1'b1};

      bus.i_w_valid = 1'b0;
      bus.i_r_en    = 1'b0;
      bus.i_data    = '0;
      do_reset();

      check("rst_level", 128'(bus.o_level), 128'd0);
      check("rst_empty", 128'(bus.o_empty), 128'd1);
      check("rst_full", 128'(bus.o_full), 128'd0);
      check("rst_rvalid", 128'(bus.o_r_valid), 128'd0);
      check("rst_underflow", 128'(bus.o_underflow), 128'd0);
      check("rst_data", bus.o_data, 128'd0);
      check("rst_ready", 128'(bus.o_w_ready), 128'd1);

      // Basic round trip from the vector table.
      for (int i = 0; i < 10; i++) begin
         bus.i_w_valid = vecs[i].w_valid;
         bus.i_r_en    = vecs[i].r_en;
         if (vecs[i].w_valid) begin
            bus.i_data = blk;
         end
         tick();
         check($sformatf("vec%0d_level", i), 128'(bus.o_level), 128'(vecs[i].exp_level));
         check($sformatf("vec%0d_rvalid", i), 128'(bus.o_r_valid), 128'(vecs[i].exp_rv));
         check($sformatf("vec%0d_ready", i), 128'(bus.o_w_ready), 128'(vecs[i].exp_ready));
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d_data", i), bus.o_data, vecs[i].exp_data);
         end
      end
      bus.i_r_en = 1'b0;

      // Back-to-back blocks A and B with valid held high.
      acc_a         = -1;
      acc_b         = -1;
      bus.i_w_valid = 1'b1;
      bus.i_data    = mk(1);
      for (int c = 0; c < 20 && acc_b < 0; c++) begin
         if (bus.o_w_ready) begin
            if (acc_a < 0) acc_a = c;
            else           acc_b = c;
         end
         tick();
         if (acc_a >= 0) bus.i_data = mk(2);
      end
      bus.i_w_valid = 1'b0;
      check("b2b_b_accepted", 128'(acc_b >= 0), 128'd1);
      check("b2b_spacing", 128'(acc_b - acc_a), 128'd5);
      repeat (RATIO) tick();
      check("b2b_level", 128'(bus.o_level), 128'd8);
      check("b2b_full", 128'(bus.o_full), 128'd1);

      // Block C waits for four free slots, then serialises under a steady read.
      bus.i_w_valid = 1'b1;
      bus.i_data    = mk(3);
      #1;
      check("c_blocked", 128'(bus.o_w_ready), 128'd0);
      for (int i = 0; i < RATIO; i++) begin
         bus.i_r_en = 1'b1;
         tick();
         check($sformatf("a_data%0d", i), bus.o_data, wd(1, i));
         check($sformatf("c_ready%0d", i), 128'(bus.o_w_ready), 128'(i == RATIO - 1));
      end
      bus.i_r_en = 1'b0;
      tick();
      bus.i_w_valid = 1'b0;
      check("c_accept_level", 128'(bus.o_level), 128'd4);
      check("c_accept_busy", 128'(bus.o_w_ready), 128'd0);
      bus.i_r_en = 1'b1;
      for (int i = 0; i < RATIO; i++) begin
         tick();
         check($sformatf("c_ser_level%0d", i), 128'(bus.o_level), 128'd4);
         check($sformatf("b_data%0d", i), bus.o_data, wd(2, i));
      end
      for (int i = 0; i < RATIO; i++) begin
         tick();
         check($sformatf("c_data%0d", i), bus.o_data, wd(3, i));
         check($sformatf("c_drain_level%0d", i), 128'(bus.o_level), 128'(3 - i));
      end
      bus.i_r_en = 1'b0;
      tick();
      check("c_empty", 128'(bus.o_empty), 128'd1);

      // Underflow from empty right after reset.
      do_reset();
      bus.i_r_en = 1'b1;
      tick();
      bus.i_r_en = 1'b0;
      check("uf_rvalid", 128'(bus.o_r_valid), 128'd0);
      check("uf_flag", 128'(bus.o_underflow), 128'd1);
      check("uf_level", 128'(bus.o_level), 128'd0);
      tick();
      check("uf_sticky", 128'(bus.o_underflow), 128'd1);
      write_block(mk(4));
      read_block(4);
      check("uf_still_set", 128'(bus.o_underflow), 128'd1);

      // Flush at slice 2 of a block with level 6.
      write_block(mk(5));
      bus.i_w_valid = 1'b1;
      bus.i_data    = mk(6);
      tick();
      bus.i_w_valid = 1'b0;
      repeat (2) tick();
      check("clr_pre_level", 128'(bus.o_level), 128'd6);
      clr           = 1'b1;
      bus.i_r_en    = 1'b1;
      bus.i_w_valid = 1'b1;
      bus.i_data    = mk(7);
      #1;
      check("clr_ready_low", 128'(bus.o_w_ready), 128'd0);
      tick();
      clr           = 1'b0;
      bus.i_r_en    = 1'b0;
      bus.i_w_valid = 1'b0;
      #1;
      check("clr_level", 128'(bus.o_level), 128'd0);
      check("clr_empty", 128'(bus.o_empty), 128'd1);
      check("clr_underflow", 128'(bus.o_underflow), 128'd0);
      check("clr_ready", 128'(bus.o_w_ready), 128'd1);
      check("clr_rvalid", 128'(bus.o_r_valid), 128'd0);
      tick();
      check("clr_discarded", 128'(bus.o_level), 128'd0);
      write_block(mk(8));
      read_block(8);

      // Asynchronous reset in the middle of a read burst.
      write_block(mk(9));
      bus.i_r_en = 1'b1;
      tick();
      check("arst_pre_rvalid", 128'(bus.o_r_valid), 128'd1);
      check("arst_pre_data", bus.o_data, wd(9, 0));
      #2;
      rstn = 1'b0;
      #1;
      check("arst_rvalid", 128'(bus.o_r_valid), 128'd0);
      check("arst_level", 128'(bus.o_level), 128'd0);
      check("arst_empty", 128'(bus.o_empty), 128'd1);
      check("arst_full", 128'(bus.o_full), 128'd0);
      check("arst_underflow", 128'(bus.o_underflow), 128'd0);
      check("arst_data", bus.o_data, 128'd0);
      bus.i_r_en = 1'b0;
      tick();
      rstn = 1'b1;
      #1;
      write_block(mk(10));
      read_block(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
